// File: rtl/mod_updown_counter.sv
// Modulo up/down event counter with prescaler, synchronous clear/load,
// a registered terminal-count pulse and a sticky wrap flag.
module mod_updown_counter #(
    parameter int WIDTH    = 20,
    parameter int MOD_VAL  = 1000000,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD_VAL - 1);
    localparam logic [PW-1:0]    PRE_TOP = PW'(PRESCALE - 1);

    generate
        if (MOD_VAL < 2 || longint'(MOD_VAL) > (longint'(1) << WIDTH)) begin : g_bad_mod
            $error("mod_updown_counter: MOD_VAL must satisfy 2 <= MOD_VAL <= 2**WIDTH");
        end
        if (PRESCALE < 1) begin : g_bad_pre
            $error("mod_updown_counter: PRESCALE must be >= 1");
        end
    endgenerate

    // Prescaler runs as a down-counter: PRE_TOP is the "just restarted"
    // value and a step fires when it reaches zero on an enabled cycle.
    logic [PW-1:0]    pre_cnt;
    logic [PW-1:0]    pre_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             ovf_nxt;
    logic             step;
    logic             wrap;

    always_comb begin
        pre_nxt   = pre_cnt;
        count_nxt = count;
        tc_nxt    = 1'b0;
        ovf_nxt   = ovf;
        step      = 1'b0;
        wrap      = 1'b0;

        if (clr) begin
            pre_nxt   = PRE_TOP;
            count_nxt = '0;
            ovf_nxt   = 1'b0;
        end else if (load) begin
            pre_nxt   = PRE_TOP;
            count_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            if (pre_cnt == '0) begin
                step    = 1'b1;
                pre_nxt = PRE_TOP;
            end else begin
                pre_nxt = pre_cnt - 1'b1;
            end
        end

        if (step) begin
            if (up_dn) begin
                wrap      = (count == MAX_VAL);
                count_nxt = wrap ? '0 : count + 1'b1;
            end else begin
                wrap      = (count == '0);
                count_nxt = wrap ? MAX_VAL : count - 1'b1;
            end
            tc_nxt  = wrap;
            ovf_nxt = ovf | wrap;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt <= PRE_TOP;
            count   <= '0;
            tc      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            pre_cnt <= pre_nxt;
            count   <= count_nxt;
            tc      <= tc_nxt;
            ovf     <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: default, MOD_VAL=10 and PRESCALE=3 instances
// checked against an expectation queue filled as stimulus is applied.
module tb_mod_updown_counter;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, rst_c;
    logic        en_a, en_b, en_c;
    logic        up_dn, clr, load;
    logic [19:0] load_val_a;
    logic [3:0]  load_val;
    logic [19:0] count_a;
    logic [3:0]  count_b, count_c;
    logic        tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c;

    always #5 clk = ~clk;

    mod_updown_counter u_a (
        .clk(clk), .reset(rst_a), .en(en_a), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val_a), .count(count_a), .tc(tc_a), .ovf(ovf_a));

    mod_updown_counter #(.WIDTH(4), .MOD_VAL(10), .PRESCALE(1)) u_b (
        .clk(clk), .reset(rst_b), .en(en_b), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .count(count_b), .tc(tc_b), .ovf(ovf_b));

    mod_updown_counter #(.WIDTH(4), .MOD_VAL(10), .PRESCALE(3)) u_c (
        .clk(clk), .reset(rst_c), .en(en_c), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .count(count_c), .tc(tc_c), .ovf(ovf_c));

    typedef struct {
        string       name;
        logic [19:0] cnt;
        logic        tc;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_pass = 0;
    int   n_total = 0;

    function automatic exp_t mk(string name, int cnt, logic t, logic o);
        exp_t x;
        x.name = name;
        x.cnt  = 20'(cnt);
        x.tc   = t;
        x.ovf  = o;
        return x;
    endfunction

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        up_dn = 1'b0; clr = 1'b0; load = 1'b0;
        load_val_a = '0; load_val = '0;
        sb.push_back(mk("reset_a", 0, 1'b0, 1'b0));
        sb.push_back(mk("reset_b", 0, 1'b0, 1'b0));
        #3;
        e = sb.pop_front(); n_total++;
        if ({count_a, tc_a, ovf_a} !== {e.cnt, e.tc, e.ovf})
            $display("FAIL %s: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                     e.name, count_a, tc_a, ovf_a, e.cnt, e.tc, e.ovf);
        else n_pass++;
        e = sb.pop_front(); n_total++;
        if ({16'd0, count_b, tc_b, ovf_b} !== {e.cnt, e.tc, e.ovf})
            $display("FAIL %s: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                     e.name, count_b, tc_b, ovf_b, e.cnt, e.tc, e.ovf);
        else n_pass++;
        #4;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    endtask

    task automatic test_default_count();
        en_a  = 1'b1;
        up_dn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            sb.push_back(mk($sformatf("default_up_%0d", i), i, 1'b0, 1'b0));
            @(posedge clk); #1;
            e = sb.pop_front(); n_total++;
            if ({count_a, tc_a, ovf_a} !== {e.cnt, e.tc, e.ovf})
                $display("FAIL %s: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                         e.name, count_a, tc_a, ovf_a, e.cnt, e.tc, e.ovf);
            else n_pass++;
        end
        en_a = 1'b0;
    endtask

    task automatic test_wrap_up();
        en_b  = 1'b1;
        up_dn = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            sb.push_back(mk($sformatf("wrap_up_%0d", i), i % 10, i == 10, i >= 10));
            @(posedge clk); #1;
            e = sb.pop_front(); n_total++;
            if ({16'd0, count_b, tc_b, ovf_b} !== {e.cnt, e.tc, e.ovf})
                $display("FAIL %s: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                         e.name, count_b, tc_b, ovf_b, e.cnt, e.tc, e.ovf);
            else n_pass++;
        end
        en_b = 1'b0;
    endtask

    task automatic test_load_down();
        int seq[6] = '{2, 1, 0, 9, 8, 9};
        for (int i = 0; i < 6; i++) begin
            load     = (i == 0) || (i == 5);
            load_val = (i == 5) ? 4'd15 : 4'd2;
            en_b     = (i >= 1) && (i <= 4);
            up_dn    = 1'b0;
            sb.push_back(mk($sformatf("load_down_%0d", i), seq[i], i == 3, 1'b1));
            @(posedge clk); #1;
            e = sb.pop_front(); n_total++;
            if ({16'd0, count_b, tc_b, ovf_b} !== {e.cnt, e.tc, e.ovf})
                $display("FAIL %s: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                         e.name, count_b, tc_b, ovf_b, e.cnt, e.tc, e.ovf);
            else n_pass++;
        end
        load = 1'b0;
        en_b = 1'b0;
    endtask

    task automatic test_clr_load_priority();
        // load 7, then clr+load+en together, then load+en with no step
        int seq[3] = '{7, 0, 5};
        logic ov[3] = '{1'b1, 1'b0, 1'b0};
        up_dn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load     = 1'b1;
            clr      = (i == 1);
            en_b     = (i >= 1);
            load_val = (i == 2) ? 4'd5 : 4'd7;
            sb.push_back(mk($sformatf("priority_%0d", i), seq[i], 1'b0, ov[i]));
            @(posedge clk); #1;
            e = sb.pop_front(); n_total++;
            if ({16'd0, count_b, tc_b, ovf_b} !== {e.cnt, e.tc, e.ovf})
                $display("FAIL %s: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                         e.name, count_b, tc_b, ovf_b, e.cnt, e.tc, e.ovf);
            else n_pass++;
        end
        load = 1'b0;
        clr  = 1'b0;
        en_b = 1'b0;
    endtask

    task automatic test_prescale();
        int seq[18] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3, 4};
        up_dn = 1'b1;
        for (int i = 0; i < 18; i++) begin
            clr  = (i == 0);
            en_c = (i >= 1 && i <= 9) || (i >= 15);
            sb.push_back(mk($sformatf("prescale_%0d", i), seq[i], 1'b0, 1'b0));
            @(posedge clk); #1;
            e = sb.pop_front(); n_total++;
            if ({16'd0, count_c, tc_c, ovf_c} !== {e.cnt, e.tc, e.ovf})
                $display("FAIL %s: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                         e.name, count_c, tc_c, ovf_c, e.cnt, e.tc, e.ovf);
            else n_pass++;
        end
        clr  = 1'b0;
        en_c = 1'b0;
    endtask

    task automatic test_async_reset();
        // load 9, wrap to 0, then count up to 6 with ovf set
        up_dn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            load     = (i == 0);
            load_val = 4'd9;
            en_b     = (i >= 1);
            sb.push_back(mk($sformatf("pre_reset_%0d", i), (i == 0) ? 9 : i - 1,
                            i == 1, i >= 1));
            @(posedge clk); #1;
            e = sb.pop_front(); n_total++;
            if ({16'd0, count_b, tc_b, ovf_b} !== {e.cnt, e.tc, e.ovf})
                $display("FAIL %s: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                         e.name, count_b, tc_b, ovf_b, e.cnt, e.tc, e.ovf);
            else n_pass++;
        end
        load = 1'b0;
        #4;
        rst_b = 1'b0;
        sb.push_back(mk("async_reset", 0, 1'b0, 1'b0));
        #1;
        e = sb.pop_front(); n_total++;
        if ({16'd0, count_b, tc_b, ovf_b} !== {e.cnt, e.tc, e.ovf})
            $display("FAIL %s: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                     e.name, count_b, tc_b, ovf_b, e.cnt, e.tc, e.ovf);
        else n_pass++;
        #2;
        rst_b = 1'b1;
        sb.push_back(mk("after_release", 1, 1'b0, 1'b0));
        @(posedge clk); #1;
        e = sb.pop_front(); n_total++;
        if ({16'd0, count_b, tc_b, ovf_b} !== {e.cnt, e.tc, e.ovf})
            $display("FAIL %s: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                     e.name, count_b, tc_b, ovf_b, e.cnt, e.tc, e.ovf);
        else n_pass++;
        en_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_count();
        test_wrap_up();
        test_load_down();
        test_clr_load_priority();
        test_prescale();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
